memwb_skid_reg: RTL

- Parametrised successor to the plain MEM/WB latch: a MEM→WB pipeline stage register with valid/ready handshake on both sides, a 2-entry skid buffer, synchronous flush and x0 write suppression.
- Sits between the MEM stage (data memory read data / ALU result) and the register-file write port.
- Allows WB back-pressure without a combinational ready path.

---
 rtl/memwb_skid_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/memwb_skid_reg.sv
// memwb_skid_reg: MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and x0 write suppression
//   Parameters: DATA_W data word width, RA_W register-address width, ZERO_SUPPRESS gates RegWrite_o for rd=0
//   Inputs : clk_i, rst_n_i (async active-low), flush_i, in_valid_i, RegWrite_i, MemReg_i, rd_addr_i, data1_i, data2_i, out_ready_i
//   Outputs: in_ready_o, out_valid_o, RegWrite_o, MemReg_o, rd_addr_o, data1_o, data2_o
//   Optional: define MEMWB_WB_MUX_EN to add wb_data_o = MemReg_o ? data1_o : data2_o
module memwb_skid_reg #(
  parameter int DATA_W        = 32,
  parameter int RA_W          = 5,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              RegWrite_i,
  input  logic              MemReg_i,
  input  logic [RA_W-1:0]   rd_addr_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              RegWrite_o,
  output logic              MemReg_o,
  output logic [RA_W-1:0]   rd_addr_o,
  output logic [DATA_W-1:0] data1_o,
`ifdef MEMWB_WB_MUX_EN
  output logic [DATA_W-1:0] wb_data_o,
`endif
  output logic [DATA_W-1:0] data2_o
);
  typedef struct packed {
    logic              rw;
    logic              mr;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic acc, drn;
  assign in_e        = {RegWrite_i, MemReg_i, rd_addr_i, data1_i, data2_i};
  // ready depends only on registered state, never on out_ready_i
  assign in_ready_o  = state_q != FULL;
  assign out_valid_o = state_q != EMPTY;
  assign acc         = in_valid_i & in_ready_o;
  assign drn         = out_valid_o & out_ready_i;
  // flush clears only the occupancy; held data words stay as they were
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        main_d  = in_e;
      end
      ONE: if (acc && drn) main_d = in_e;
      else if (acc) begin
        state_d = FULL;
        skid_d  = in_e;
      end
      else if (drn) state_d = EMPTY;
      FULL: if (drn) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  assign RegWrite_o = out_valid_o & main_q.rw & ~(ZERO_SUPPRESS & (main_q.rd == '0));
  assign MemReg_o   = main_q.mr;
  assign rd_addr_o  = main_q.rd;
  assign data1_o    = main_q.d1;
  assign data2_o    = main_q.d2;
`ifdef MEMWB_WB_MUX_EN
  assign wb_data_o  = main_q.mr ? main_q.d1 : main_q.d2;
`endif
endmodule
